// File: rtl/cxu_l2_l0_adapter_pkg.sv
// Shared types and limits for the CXU-L2 to CXU-L0 adapter slice.
// Also holds the elaboration-time parameter legality helpers.
package cxu_l2_l0_adapter_pkg;

   localparam int CXU_STATUS_W = 3;

   typedef enum logic [CXU_STATUS_W-1:0] {
      CXU_OK    = 3'd0,
      CXU_ERROR = 3'd1,
      CXU_OFF   = 3'd2
   } cxu_status_t;

   localparam int CXU_L2_MAX_LATENCY = 4;

   function automatic bit check_param_range(input int val, input int lo, input int hi);
      return (val >= lo) && (val <= hi);
   endfunction

   function automatic bit check_param_pow2(input int val);
      return (val > 32'sd0) && ((val & (val - 32'sd1)) == 32'sd0);
   endfunction

   function automatic int clog2_min1(input int val);
      return (val > 32'sd1) ? $clog2(val) : 32'sd1;
   endfunction

endpackage

// File: rtl/cxu_l2_l0_adapter_if.sv
// CXU request/response bundle; master drives requests, slave answers them.
interface cxu_l2_l0_adapter_if
   import cxu_l2_l0_adapter_pkg::*;
#(
   parameter int CXU_ID_W = 1,
   parameter int FUNC_W   = 1,
   parameter int DATA_W   = 32
);
   logic                    req_valid;
   logic                    req_ready;
   logic [CXU_ID_W-1:0]     req_cxu;
   logic [FUNC_W-1:0]       req_func;
   logic [DATA_W-1:0]       req_data0;
   logic [DATA_W-1:0]       req_data1;
   logic                    resp_valid;
   logic                    resp_ready;
   logic [CXU_STATUS_W-1:0] resp_status;
   logic [DATA_W-1:0]       resp_data;

   modport master (
      output req_valid, req_cxu, req_func, req_data0, req_data1, resp_ready,
      input  req_ready, resp_valid, resp_status, resp_data
   );

   modport slave (
      input  req_valid, req_cxu, req_func, req_data0, req_data1, resp_ready,
      output req_ready, resp_valid, resp_status, resp_data
   );
endinterface

// File: rtl/cxu_l2_l0_adapter_resp_fifo.sv
// Synchronous first-word-fall-through FIFO holding pipeline results until the
// CPU accepts them.
module cxu_l2_l0_adapter_resp_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic         empty,
   output logic         full
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic          push_ok_s;
   logic          pop_ok_s;

   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
      if (p == AW'(DEPTH - 1)) begin
         return {AW{1'b0}};
      end else begin
         return p + AW'(1'b1);
      end
   endfunction

   assign empty     = (count_r == {CW{1'b0}});
   assign full      = (count_r == CW'(DEPTH));
   assign pop_ok_s  = pop & ~empty;
   assign push_ok_s = push & (~full | pop_ok_s);
   assign rdata     = mem_r[rd_ptr_r];

   // Storage write; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= next_ptr(wr_ptr_r);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= next_ptr(rd_ptr_r);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CW'(1'b1);
            2'b01:   count_r <= count_r - CW'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end
endmodule

// File: rtl/cxu_l2_l0_adapter.sv
// Puts a combinational CXU-L0 behind a CXU-L2 handshake: fixed-latency result
// pipeline plus a response FIFO so the CPU may stall responses.
module cxu_l2_l0_adapter
   import cxu_l2_l0_adapter_pkg::*;
#(
   parameter int N_CXUS     = 1,
   parameter int FUNC_ID_W  = 0,
   parameter int DATA_W     = 32,
   parameter int LATENCY    = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clk_en,
   cxu_l2_l0_adapter_if.slave  cpu,
   cxu_l2_l0_adapter_if.master l0
);
   localparam int OCC_W   = $clog2(FIFO_DEPTH + 1);
   localparam int ENTRY_W = CXU_STATUS_W + DATA_W;

   if (!check_param_range(N_CXUS, 32'sd1, 32'sd1024)) begin : g_bad_n_cxus
      $error("cxu_l2_l0_adapter: N_CXUS out of range");
   end
   if (!check_param_range(FUNC_ID_W, 32'sd0, 32'sd16)) begin : g_bad_func_id_w
      $error("cxu_l2_l0_adapter: FUNC_ID_W out of range");
   end
   if ((DATA_W != 32'sd32) && (DATA_W != 32'sd64)) begin : g_bad_data_w
      $error("cxu_l2_l0_adapter: DATA_W must be 32 or 64");
   end
   if (!check_param_range(LATENCY, 32'sd1, CXU_L2_MAX_LATENCY)) begin : g_bad_latency
      $error("cxu_l2_l0_adapter: LATENCY out of range");
   end
   if (!check_param_pow2(FIFO_DEPTH) || (FIFO_DEPTH < LATENCY)) begin : g_bad_fifo_depth
      $error("cxu_l2_l0_adapter: FIFO_DEPTH must be a power of 2 and >= LATENCY");
   end

   logic                    run_s;
   logic [OCC_W-1:0]        occ_r;
   logic                    ready_s;
   logic                    accept_s;
   logic                    retire_s;
   logic                    resp_valid_s;
   logic                    pipe_valid_r  [LATENCY];
   logic [CXU_STATUS_W-1:0] pipe_status_r [LATENCY];
   logic [DATA_W-1:0]       pipe_data_r   [LATENCY];
   logic                    last_valid_s;
   logic                    fifo_push_s;
   logic                    fifo_pop_s;
   logic                    fifo_empty_s;
   logic                    fifo_full_s;
   logic [ENTRY_W-1:0]      fifo_rdata_s;
   logic [CXU_STATUS_W-1:0] head_status_s;
   logic [DATA_W-1:0]       head_data_s;

   assign run_s        = clk_en & ~rst;
   assign ready_s      = run_s & (occ_r < OCC_W'(FIFO_DEPTH));
   assign accept_s     = cpu.req_valid & ready_s;
   assign last_valid_s = pipe_valid_r[LATENCY-1];
   assign resp_valid_s = run_s & (~fifo_empty_s | last_valid_s);
   assign retire_s     = resp_valid_s & cpu.resp_ready;

   // The last stage bypasses the FIFO only when the CPU takes it right away.
   assign fifo_push_s  = run_s & last_valid_s & ~(retire_s & fifo_empty_s);
   assign fifo_pop_s   = retire_s & ~fifo_empty_s;

   assign l0.req_valid  = accept_s;
   assign l0.req_cxu    = cpu.req_cxu;
   assign l0.req_func   = cpu.req_func;
   assign l0.req_data0  = cpu.req_data0;
   assign l0.req_data1  = cpu.req_data1;
   assign l0.resp_ready = 1'b1;

   assign cpu.req_ready  = ready_s;
   assign cpu.resp_valid = resp_valid_s;

   // Outstanding-request credit counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         occ_r <= {OCC_W{1'b0}};
      end else if (clk_en) begin
         case ({accept_s, retire_s})
            2'b10:   occ_r <= occ_r + OCC_W'(1'b1);
            2'b01:   occ_r <= occ_r - OCC_W'(1'b1);
            default: occ_r <= occ_r;
         endcase
      end
   end

   // Fixed-latency result pipeline fed by the combinational L0 answer.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < LATENCY; k++) begin
            pipe_valid_r[k] <= 1'b0;
         end
      end else if (clk_en) begin
         pipe_valid_r[0]  <= accept_s;
         pipe_status_r[0] <= l0.resp_status;
         pipe_data_r[0]   <= l0.resp_data;
         for (int k = 1; k < LATENCY; k++) begin
            pipe_valid_r[k]  <= pipe_valid_r[k-1];
            pipe_status_r[k] <= pipe_status_r[k-1];
            pipe_data_r[k]   <= pipe_data_r[k-1];
         end
      end
   end

   cxu_l2_l0_adapter_resp_fifo #(
      .W     (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_resp_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push_s),
      .pop   (fifo_pop_s),
      .wdata ({pipe_status_r[LATENCY-1], pipe_data_r[LATENCY-1]}),
      .rdata (fifo_rdata_s),
      .empty (fifo_empty_s),
      .full  (fifo_full_s)
   );

   // Older results waiting in the FIFO always go before the live last stage.
   always_comb begin
      head_status_s = {CXU_STATUS_W{1'b0}};
      head_data_s   = {DATA_W{1'b0}};
      if (!fifo_empty_s) begin
         {head_status_s, head_data_s} = fifo_rdata_s;
      end else begin
         head_status_s = pipe_status_r[LATENCY-1];
         head_data_s   = pipe_data_r[LATENCY-1];
      end
   end

   assign cpu.resp_status = resp_valid_s ? head_status_s : {CXU_STATUS_W{1'b0}};
   assign cpu.resp_data   = resp_valid_s ? head_data_s   : {DATA_W{1'b0}};

   wire _unused_ok = &{1'b0, l0.req_ready, l0.resp_valid, fifo_full_s, 1'b0};
endmodule

// File: tb/tb_cxu_l2_l0_adapter.sv
// Directed bench for cxu_l2_l0_adapter with a popcount L0, DATA_W=32,
// LATENCY=2, FIFO_DEPTH=4.
module tb_cxu_l2_l0_adapter;
   import cxu_l2_l0_adapter_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic clk_en;
   int   checks = 0;
   int   errors = 0;
   int   cyc_n  = 0;

   always #5 clk = ~clk;

   cxu_l2_l0_adapter_if #(.CXU_ID_W(1), .FUNC_W(1), .DATA_W(32)) cpu_if ();
   cxu_l2_l0_adapter_if #(.CXU_ID_W(1), .FUNC_W(1), .DATA_W(32)) l0_if ();

   // Popcount L0 CXU.
   assign l0_if.resp_data   = 32'($countones(l0_if.req_data0));
   assign l0_if.resp_status = CXU_OK;
   assign l0_if.req_ready   = 1'b1;
   assign l0_if.resp_valid  = 1'b0;

   cxu_l2_l0_adapter #(
      .N_CXUS     (1),
      .FUNC_ID_W  (0),
      .DATA_W     (32),
      .LATENCY    (2),
      .FIFO_DEPTH (4)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .clk_en (clk_en),
      .cpu    (cpu_if),
      .l0     (l0_if)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle %0d observed %0h expected %0h", tag, cyc_n, obs, exp);
      end
   endtask

   // One cycle: drive inputs, check outputs mid-cycle, advance past the edge.
   task automatic cyc(input string tag, input logic rv, input logic [31:0] d,
                      input logic rr, input logic ce, input logic rs,
                      input logic er, input logic elv, input logic ev,
                      input logic [31:0] ed);
      rst              = rs;
      clk_en           = ce;
      cpu_if.req_valid = rv;
      cpu_if.req_data0 = d;
      cpu_if.resp_ready = rr;
      @(negedge clk);
      chk({tag, ".req_ready"},    64'(cpu_if.req_ready),   64'(er));
      chk({tag, ".l0_req_valid"}, 64'(l0_if.req_valid),    64'(elv));
      chk({tag, ".resp_valid"},   64'(cpu_if.resp_valid),  64'(ev));
      chk({tag, ".resp_data"},    64'(cpu_if.resp_data),   64'(ed));
      chk({tag, ".resp_status"},  64'(cpu_if.resp_status), 64'(CXU_OK));
      @(posedge clk);
      #1;
      cyc_n++;
   endtask

   initial begin
      #100000;
      errors++;
      $display("FAIL watchdog expired observed running expected finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] b2b_in  [8];
      logic [31:0] b2b_exp [8];
      b2b_in  = '{32'h0, 32'h1, 32'h3, 32'h7, 32'hF, 32'hFF, 32'hFFFF, 32'hFFFF_FFFF};
      b2b_exp = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd8, 32'd16, 32'd32};

      rst               = 1'b1;
      clk_en            = 1'b1;
      cpu_if.req_valid  = 1'b1;
      cpu_if.req_cxu    = 1'b0;
      cpu_if.req_func   = 1'b0;
      cpu_if.req_data0  = 32'h0;
      cpu_if.req_data1  = 32'h0;
      cpu_if.resp_ready = 1'b1;
      @(posedge clk);
      #1;

      // Reset holds both handshakes low even with req_valid high.
      //   tag        rv    d      rr    ce    rs    er    elv   ev    ed
      cyc("rst",     1'b1, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      cyc("rst",     1'b1, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      cyc("rst_rel", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);

      // Single request: response exactly LATENCY cycles later.
      cyc("single", 1'b1, 32'hFFFF_0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      cyc("single", 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      cyc("single", 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd16);
      cyc("single", 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);

      // Back-to-back stream at full throughput.
      for (int c = 0; c < 10; c++) begin
         cyc("b2b", (c < 8), (c < 8) ? b2b_in[c] : 32'h0, 1'b1, 1'b1, 1'b0,
             1'b1, (c < 8), (c >= 2), (c >= 2) ? b2b_exp[c-2] : 32'd0);
      end
      cyc("b2b", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);

      // Backpressure: four accepted, fifth waits for a freed credit.
      cyc("bp", 1'b1, 32'h1,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      cyc("bp", 1'b1, 32'h3,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      cyc("bp", 1'b1, 32'h7,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'd1);
      cyc("bp", 1'b1, 32'hF,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'd1);
      cyc("bp", 1'b1, 32'h1F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1);
      cyc("bp", 1'b1, 32'h1F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1);
      cyc("bp", 1'b1, 32'h1F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1);
      cyc("bp", 1'b1, 32'h1F, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'd2);
      cyc("bp", 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd3);
      cyc("bp", 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd4);
      cyc("bp", 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd5);
      cyc("bp", 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);

      // Three outstanding, then accept and retire together twice.
      cyc("occ3", 1'b1, 32'h11,   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      cyc("occ3", 1'b1, 32'h111,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      cyc("occ3", 1'b1, 32'h1111, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'd2);
      cyc("occ3", 1'b1, 32'hFF,   1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'd2);
      cyc("occ3", 1'b1, 32'h1,    1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'd3);
      cyc("occ3", 1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd4);
      cyc("occ3", 1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd8);
      cyc("occ3", 1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd1);
      cyc("occ3", 1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);

      // Mid-stream reset discards everything in flight.
      cyc("midrst", 1'b1, 32'h1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      cyc("midrst", 1'b1, 32'h3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      cyc("midrst", 1'b1, 32'h7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'd1);
      cyc("midrst", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      cyc("midrst", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      cyc("midrst", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      cyc("midrst", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);

      // Clock enable low freezes the pipeline and idles the outputs.
      cyc("clken", 1'b1, 32'hF,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      cyc("clken", 1'b1, 32'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      cyc("clken", 1'b1, 32'h3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      cyc("clken", 1'b1, 32'h3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      cyc("clken", 1'b1, 32'h3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      cyc("clken", 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd4);
      cyc("clken", 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd8);
      cyc("clken", 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
